// File: rtl/cla192_modsub_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla192_pkg : shared widths, types and default modulus for the 192-bit      |
// |              modular subtractor pipe.                                      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package cla192_pkg;

  localparam int GRP_W = 64;
  localparam int NGRP  = 3;
  localparam int W     = GRP_W * NGRP;

  typedef logic [GRP_W-1:0] grp_t;
  typedef logic [W-1:0]     word_t;

  // P-192 field prime, 2^192 - 2^64 - 1.
  localparam word_t MOD_P192 =
    192'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFF;

  function automatic grp_t grp_of(input word_t w, input int g);
    return w[g*GRP_W +: GRP_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla192_modsub_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla192_modsub_pipe_if : operand/result valid-ready bus of the subtractor.  |
// | Revision              : 1.0                                                |
// +----------------------------------------------------------------------------+
interface cla192_modsub_pipe_if;
  import cla192_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_a;
  word_t in_b;
  logic  out_valid;
  logic  out_ready;
  word_t out_d;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_d
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_d
  );

endinterface
`default_nettype wire

// File: rtl/cla192_modsub_pipe_sub64_grp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sub64_grp : one 64-bit group of the borrow chain and the MOD add-back sum. |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module sub64_grp
  import cla192_pkg::*;
(
  input  grp_t a_i,
  input  grp_t b_i,
  input  logic bor_in_i,
  input  grp_t mod_i,
  input  logic cy_in_i,
  output grp_t d_o,
  output logic bor_out_o,
  output grp_t e_o,
  output logic cy_out_o
);

  logic [GRP_W:0] dif_w;
  logic [GRP_W:0] sum_w;

  // The extra top bit of the widened difference is set exactly when it went negative.
  assign dif_w     = {1'b0, a_i} - {1'b0, b_i} - {{GRP_W{1'b0}}, bor_in_i};
  assign d_o       = dif_w[GRP_W-1:0];
  assign bor_out_o = dif_w[GRP_W];

  assign sum_w    = {1'b0, dif_w[GRP_W-1:0]} + {1'b0, mod_i} + {{GRP_W{1'b0}}, cy_in_i};
  assign e_o      = sum_w[GRP_W-1:0];
  assign cy_out_o = sum_w[GRP_W];

endmodule
`default_nettype wire

// File: rtl/cla192_modsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla192_modsub_pipe : 3-stage (a - b) mod MOD, one 64-bit group per stage.  |
// | Optional wrap counter with CLA192_MODSUB_WRAPCNT_EN.   Revision : 1.0      |
// +----------------------------------------------------------------------------+
module cla192_modsub_pipe
  import cla192_pkg::*;
#(
  parameter word_t MOD = MOD_P192
)
(
  input  logic clk,
  input  logic rst_n,
  cla192_modsub_pipe_if.slave bus
`ifdef CLA192_MODSUB_WRAPCNT_EN
  ,
  output logic [31:0] wrap_cnt
`endif
);

  localparam grp_t MOD0 = MOD[0*GRP_W +: GRP_W];
  localparam grp_t MOD1 = MOD[1*GRP_W +: GRP_W];
  localparam grp_t MOD2 = MOD[2*GRP_W +: GRP_W];

  logic en;

  // Stage 1
  logic               v1_q;
  grp_t               dif0_q, e0_q;
  logic               bor0_q, cy0_q;
  logic [2*GRP_W-1:0] a21_q, b21_q;

  // Stage 2
  logic               v2_q;
  logic [2*GRP_W-1:0] dif10_q, e10_q;
  logic               bor1_q, cy1_q;
  grp_t               a2_q, b2_q;

  // Stage 3
  logic               v3_q;
  word_t              res_q;

  grp_t  dif0_d, e0_d, dif1_d, e1_d, dif2_d, e2_d;
  logic  bor0_d, cy0_d, bor1_d, cy1_d, bor2_w;
  logic  cy2_unused;
  word_t res_d;

  sub64_grp u_grp0 (
    .a_i       (grp_of(bus.in_a, 0)),
    .b_i       (grp_of(bus.in_b, 0)),
    .bor_in_i  (1'b0),
    .mod_i     (MOD0),
    .cy_in_i   (1'b0),
    .d_o       (dif0_d),
    .bor_out_o (bor0_d),
    .e_o       (e0_d),
    .cy_out_o  (cy0_d)
  );

  sub64_grp u_grp1 (
    .a_i       (a21_q[GRP_W-1:0]),
    .b_i       (b21_q[GRP_W-1:0]),
    .bor_in_i  (bor0_q),
    .mod_i     (MOD1),
    .cy_in_i   (cy0_q),
    .d_o       (dif1_d),
    .bor_out_o (bor1_d),
    .e_o       (e1_d),
    .cy_out_o  (cy1_d)
  );

  sub64_grp u_grp2 (
    .a_i       (a2_q),
    .b_i       (b2_q),
    .bor_in_i  (bor1_q),
    .mod_i     (MOD2),
    .cy_in_i   (cy1_q),
    .d_o       (dif2_d),
    .bor_out_o (bor2_w),
    .e_o       (e2_d),
    .cy_out_o  (cy2_unused)
  );

  // A final borrow means a < b, so the MOD add-back lane holds the reduced value.
  assign res_d = bor2_w ? {e2_d, e10_q} : {dif2_d, dif10_q};

  assign en            = !v3_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v3_q;
  assign bus.out_d     = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      dif0_q  <= '0;
      e0_q    <= '0;
      bor0_q  <= 1'b0;
      cy0_q   <= 1'b0;
      a21_q   <= '0;
      b21_q   <= '0;
      v2_q    <= 1'b0;
      dif10_q <= '0;
      e10_q   <= '0;
      bor1_q  <= 1'b0;
      cy1_q   <= 1'b0;
      a2_q    <= '0;
      b2_q    <= '0;
      v3_q    <= 1'b0;
      res_q   <= '0;
    end else if (en) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (bus.in_valid) begin
        dif0_q <= dif0_d;
        e0_q   <= e0_d;
        bor0_q <= bor0_d;
        cy0_q  <= cy0_d;
        a21_q  <= bus.in_a[W-1:GRP_W];
        b21_q  <= bus.in_b[W-1:GRP_W];
      end
      if (v1_q) begin
        dif10_q <= {dif1_d, dif0_q};
        e10_q   <= {e1_d, e0_q};
        bor1_q  <= bor1_d;
        cy1_q   <= cy1_d;
        a2_q    <= a21_q[2*GRP_W-1:GRP_W];
        b2_q    <= b21_q[2*GRP_W-1:GRP_W];
      end
      if (v2_q) begin
        res_q <= res_d;
      end
    end
  end

`ifdef CLA192_MODSUB_WRAPCNT_EN
  logic [31:0] wrap_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt_q <= '0;
    end else if (en && v2_q && bor2_w) begin
      wrap_cnt_q <= wrap_cnt_q + 32'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla192_modsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cla192_modsub_pipe : scoreboard bench for the 192-bit modular subtractor|
// | Revision              : 1.0                                                |
// +----------------------------------------------------------------------------+
module tb_cla192_modsub_pipe;
  import cla192_pkg::*;

  typedef struct packed {
    word_t d;
    logic  wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cla192_modsub_pipe_if bus_if ();

`ifdef CLA192_MODSUB_WRAPCNT_EN
  logic [31:0] wrap_cnt;
`endif

  cla192_modsub_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if)
`ifdef CLA192_MODSUB_WRAPCNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  int    checks    = 0;
  int    failures  = 0;
  int    exp_wrap  = 0;
  logic  prev_stall = 1'b0;
  word_t prev_d;

  localparam word_t MODM1 = MOD_P192 - 192'd1;
  localparam word_t WRAP_3_5 =
    192'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFD;
  localparam word_t CROSS_RES =
    192'h0000000000000000_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF;
  localparam word_t TWO64  = 192'h1_0000000000000000;
  localparam word_t TWO128 = 192'h1_0000000000000000_0000000000000000;

  task automatic check(input string name, input word_t act, input word_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops on every accepted result, also checks stall behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_d", bus_if.out_d, prev_d);
        check("stall_hold_valid", word_t'(bus_if.out_valid), 192'd1);
      end
      if (bus_if.out_valid && !bus_if.out_ready) begin
        check("stall_in_ready", word_t'(bus_if.in_ready), 192'd0);
        prev_stall = 1'b1;
        prev_d     = bus_if.out_d;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", bus_if.out_d);
        end else begin
          e = exp_q.pop_front();
          check("result", bus_if.out_d, e.d);
`ifdef CLA192_MODSUB_WRAPCNT_EN
          if (e.wrap) exp_wrap++;
          check("wrap_cnt", word_t'(wrap_cnt), word_t'(exp_wrap));
`endif
        end
      end
    end
  end

  task automatic send(input word_t a, input word_t b, input word_t exp_d, input logic wrap);
    int   n;
    exp_t e;
    n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    @(negedge clk);
    while (!bus_if.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus_if.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end else begin
      e.d    = exp_d;
      e.wrap = wrap;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  // Called just after the accepting edge: valid must appear after the third edge.
  task automatic check_latency(input string tag);
    @(negedge clk);
    check({tag, "_lat_e1"}, word_t'(bus_if.out_valid), 192'd0);
    @(negedge clk);
    check({tag, "_lat_e2"}, word_t'(bus_if.out_valid), 192'd0);
    @(negedge clk);
    check({tag, "_lat_e3"}, word_t'(bus_if.out_valid), 192'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_if.out_valid) && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || bus_if.out_valid) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    bus_if.in_valid  = 1'b1;
    bus_if.in_a      = 192'd7;
    bus_if.in_b      = 192'd1;
    bus_if.out_ready = 1'b1;
    rst_n            = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_out_valid", word_t'(bus_if.out_valid), 192'd0);
    check("reset_out_d", bus_if.out_d, 192'd0);
`ifdef CLA192_MODSUB_WRAPCNT_EN
    check("reset_wrap_cnt", word_t'(wrap_cnt), 192'd0);
`endif

    // Release with in_valid still high: the next edge is the first accept.
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    e.d    = 192'd6;
    e.wrap = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    check_latency("release");
    wait_drain();

    send(192'd5, 192'd3, 192'd2, 1'b0);
    check_latency("simple");
    wait_drain();

    send(192'd3, 192'd5, WRAP_3_5, 1'b1);
    send(TWO128, 192'd1, CROSS_RES, 1'b0);
    send(MODM1, 192'd0, MODM1, 1'b0);
    send(192'd0, MODM1, 192'd1, 1'b1);
    send(TWO64, TWO64 + 192'd1, MODM1, 1'b1);
    wait_drain();

    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(word_t'(i + 10), word_t'(i), 192'd10, 1'b0);
        end
      end
      begin
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!bus_if.out_valid && n < 30) begin
          n++;
          @(posedge clk);
          #1;
        end
        if (!bus_if.out_valid) begin
          checks++;
          failures++;
          $display("FAIL stall_wait actual=no_valid required=valid");
        end else begin
          bus_if.out_ready = 1'b0;
          repeat (2) @(posedge clk);
          #1;
          bus_if.out_ready = 1'b1;
        end
      end
    join
    wait_drain();

    send(192'd100, 192'd1, 192'd99, 1'b0);
    send(192'd200, 192'd2, 192'd198, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", word_t'(bus_if.out_valid), 192'd0);
    check("midrst_out_d", bus_if.out_d, 192'd0);
`ifdef CLA192_MODSUB_WRAPCNT_EN
    check("midrst_wrap_cnt", word_t'(wrap_cnt), 192'd0);
`endif
    exp_q.delete();
    exp_wrap = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(192'd50, 192'd8, 192'd42, 1'b0);
    wait_drain();

    send(192'd0, 192'd1, MODM1, 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla192_modsub_pipe.md
# cla192_modsub_pipe

Pipelined 192-bit modular subtractor computing (a − b) mod MOD over three 64-bit groups. It is the borrow-chain counterpart of the CLA192 carry-lookahead adder path and feeds the subtract leg of the radix-16 butterfly in the 16384-point FFT datapath. Each stage resolves one 64-bit group of both the raw difference and the add-back sum, so the group borrow and carry move one stage per cycle. A valid/ready handshake lets the butterfly back-pressure the pipe.

## Interface
- MOD, 192'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFF, field modulus. Operands must satisfy a, b < MOD.
- GRP_W, 64, group width. Fixed: 3×GRP_W = 192.
- clk  in  1  single clock. All state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  pipe accepts the operand pair this cycle.
- in_a  in  192  minuend.
- in_b  in  192  subtrahend.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_d  out  192  (in_a − in_b) mod MOD.
- wrap_cnt  out  32  count of results that needed MOD add-back. Present only with CLA192_MODSUB_WRAPCNT_EN.

## Operation
- Per group g (g = 0, 1, 2):
  - Difference lane: d_g = a_g − b_g − bor_{g−1}. bor_{−1} = 0.
  - Add-back lane: e_g = d_g + MOD_g + cy_{g−1}, mod 2^64. cy_{−1} = 0.
- Final borrow bor_2 selects the result: out_d = bor_2 ? e : d. Because a, b < MOD, e always lies in [0, MOD).
- Stage 1 registers:
  - d_0, e_0, bor_0, cy_0.
  - a_2:1 and b_2:1, carried forward.
  - v1.
- Stage 2 registers:
  - d_1:0, e_1:0, bor_1, cy_1.
  - a_2 and b_2, carried forward.
  - v2.
- Stage 3 registers:
  - The selected 192-bit result, which drives out_d.
  - v3, which drives out_valid.
- Operand values ≥ MOD are outside the contract. Output for such operands is the unreduced 192-bit selection, with no flag.

## Timing
- Reset (rst_n low, asynchronous):
  - v1, v2, v3 = 0.
  - All data registers = 0, so out_d = 0.
  - wrap_cnt = 0.
- Global stage enable en = !v3 | out_ready. in_ready = en, combinational.
- When en = 1:
  - All stages advance: v1 ← in_valid, v2 ← v1, v3 ← v2.
  - Data registers load only when the upstream valid is 1. Bubbles keep their old data.
- When en = 0, every register holds.
- Latency: 3 cycles from the in_valid & in_ready edge to out_valid.
- Throughput: 1 result per cycle while out_ready = 1.
- Back-pressure: with out_valid = 1 and out_ready = 0, in_ready drops in the same cycle and no data is lost or duplicated. Bubbles are not compacted while stalled.
- Output stability: out_d and out_valid stay stable while out_valid & !out_ready.
- Reset asserted mid-operation: all in-flight results are discarded. out_valid = 0 from the reset assertion onward. The first accept is allowed in the first clk edge after rst_n rises.

## Configuration
- CLA192_MODSUB_WRAPCNT_EN defined:
  - 32-bit wrap_cnt port and counter are present.
  - The counter increments when stage 3 loads a valid result with bor_2 = 1.
  - It wraps from 0xFFFFFFFF to 0 and is cleared only by reset.
- Undefined: no wrap_cnt port, no counter logic. Datapath and timing are identical.

## Structure
- Package cla192_pkg holds:
  - GRP_W = 64, NGRP = 3, W = 192.
  - typedef grp_t (64-bit) and typedef word_t (192-bit).
  - Default modulus constant MOD_P192.
- Sub-module sub64_grp (combinational, instantiated 3×). Inputs: a_g, b_g, bor_in, mod_g, cy_in. Outputs: d_g, bor_out, e_g, cy_out.
- Pipeline registers, handshake and counter live in the top module.

## Test plan
- Reset: assert rst_n = 0 with in_valid = 1 → out_valid = 0, out_d = 0, wrap_cnt = 0. No output until 3 cycles after the first accept following release.
- Simple difference: a = 5, b = 3, out_ready = 1 → out_d = 2 exactly 3 cycles later; wrap_cnt unchanged.
- Wrap: a = 3, b = 5 → out_d = FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFD; wrap_cnt increments by 1.
- Cross-group borrow: a = 2^128, b = 1 → out_d = 0000000000000000_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF, no wrap.
- Stall: stream 6 back-to-back pairs (a = i + 10, b = i, i = 0..5) and hold out_ready = 0 for 2 cycles once out_valid rises → in_ready low during the stall; all six results equal 10 in order; out_d stable while stalled.
- Reset mid-stream: pulse rst_n low with 2 results in flight → out_valid = 0 immediately and both results are discarded; the next pair after release produces the correct result.
